// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package rst_seq_pkg;

  localparam int unsigned MaxCh   = 32;
  localparam int unsigned MaxIdxW = 5;

  typedef enum logic [1:0] {
    StSync,
    StGap,
    StHold,
    StDone
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [MaxIdxW-1:0] idx;
  } idx_t;

  // Lowest set bit of req, with a valid flag for the all-zero case.
  function automatic idx_t lowest_set_idx(input logic [MaxCh-1:0] req);
    idx_t res;
    res = '0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (req[i]) begin
        res.valid = 1'b1;
        res.idx   = MaxIdxW'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Async-assert, sync-deassert reset synchroniser; exposes the final stage and
// the stage before it so a consumer can act on the same edge the output rises.
module rst_sync_cell #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_rstn_o,
  output logic pre_rstn_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_rstn_o = sync_q[SYNC_STAGES-1];
  assign pre_rstn_o  = sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/reset_release_seq.sv
// Sequenced release of NUM_CH reset domains with per-channel soft reset and a
// scan bypass that ties every output to rstn_i.
module reset_release_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CNT_W       =
    $clog2(((GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES) + 1)
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              test_mode,
  input  logic [NUM_CH-1:0] sw_rst_req,
  output logic [NUM_CH-1:0] rstn_o,
  output logic              rst_done,
  output logic              busy
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IdxW-1:0]  LastCh   = IdxW'(NUM_CH - 1);

  logic sync_rstn, pre_rstn;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0] rel_q, rel_d;
  logic              done_q, done_d;

  idx_t              req_lo;
  logic [IdxW-1:0]   req_idx;
  logic [NUM_CH-1:0] keep_mask;

  rst_sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk),
    .rst_ni     (rstn_i),
    .sync_rstn_o(sync_rstn),
    .pre_rstn_o (pre_rstn)
  );

  always_comb begin
    req_lo    = lowest_set_idx(MaxCh'(sw_rst_req));
    req_idx   = req_lo.idx[IdxW-1:0];
    // Channels below the requested index keep their current level.
    keep_mask = (NUM_CH'(1) << req_idx) - NUM_CH'(1);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StSync;
      cnt_q    <= '0;
      ch_idx_q <= '0;
      rel_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_idx_q <= ch_idx_d;
      rel_q    <= rel_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_idx_d = ch_idx_q;
    rel_d    = rel_q;
    done_d   = done_q;
    case (state_q)
      StSync: begin
        // Leave on the edge the synchroniser output rises, so the first gap
        // starts counting on that same edge.
        if (pre_rstn || sync_rstn) begin
          state_d  = StGap;
          cnt_d    = '0;
          ch_idx_d = '0;
        end
      end
      StGap, StDone: begin
        if (req_lo.valid) begin
          rel_d    = rel_q & keep_mask;
          done_d   = 1'b0;
          state_d  = StHold;
          cnt_d    = '0;
          ch_idx_d = (req_idx < ch_idx_q) ? req_idx : ch_idx_q;
        end else if (state_q == StGap) begin
          if (cnt_q == GapLast) begin
            rel_d[ch_idx_q] = 1'b1;
            cnt_d           = '0;
            if (ch_idx_q == LastCh) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              ch_idx_d = ch_idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StHold: begin
        if (req_lo.valid) begin
          cnt_d = '0;
          if (req_idx < ch_idx_q) begin
            rel_d    = rel_q & keep_mask;
            ch_idx_d = req_idx;
          end
        end else if (cnt_q == HoldLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q != StDone);
    rstn_o   = test_mode ? {NUM_CH{rstn_i}} : rel_q;
    rst_done = test_mode ? rstn_i : done_q;
  end

endmodule

// File: tb/tb_reset_release_seq.sv
// Randomised and directed checks of reset_release_seq against a timeline model.
module tb_reset_release_seq;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int GAP  = 16;
  localparam int HOLD = 8;

  logic           clk = 1'b0;
  logic           rstn_i = 1'b0;
  logic           test_mode = 1'b0;
  logic [NCH-1:0] sw_rst_req = '0;
  logic [NCH-1:0] rstn_o;
  logic           rst_done;
  logic           busy;
  logic [5:0]     got;

  int checks = 0;
  int errors = 0;

  // Timeline model: phase 0 waiting, 1 sequencing, 2 holding, 3 all released.
  int         t, phase, nxt, release_at, quiet;
  logic [3:0] rel;

  reset_release_seq #(
    .NUM_CH     (NCH),
    .SYNC_STAGES(SYNC),
    .GAP_CYCLES (GAP),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .test_mode (test_mode),
    .sw_rst_req(sw_rst_req),
    .rstn_o    (rstn_o),
    .rst_done  (rst_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  assign got = {rstn_o, rst_done, busy};

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [5:0] exp_vec();
    logic [3:0] o;
    logic       d;
    o = test_mode ? {4{rstn_i}} : rel;
    d = test_mode ? rstn_i : (phase == 3);
    return {o, d, (phase != 3)};
  endfunction

  task automatic model_reset();
    t = 0; phase = 0; nxt = 0; release_at = 0; quiet = 0; rel = '0;
  endtask

  task automatic model_step(input logic [3:0] req);
    int k;
    if (!rstn_i) begin
      model_reset();
      return;
    end
    t++;
    k = lowest(req);
    case (phase)
      0: if (t == SYNC) begin phase = 1; release_at = t + GAP; end
      1, 3: begin
        if (k >= 0) begin
          rel   = rel & ((4'd1 << k) - 4'd1);
          nxt   = (k < nxt) ? k : nxt;
          phase = 2;
          quiet = 0;
        end else if (phase == 1 && t == release_at) begin
          rel[nxt] = 1'b1;
          nxt++;
          if (nxt == NCH) phase = 3;
          else release_at = t + GAP;
        end
      end
      default: begin
        if (k >= 0) begin
          quiet = 0;
          if (k < nxt) begin
            rel = rel & ((4'd1 << k) - 4'd1);
            nxt = k;
          end
        end else begin
          quiet++;
          if (quiet == HOLD) begin
            phase = 1;
            quiet = 0;
            release_at = t + GAP;
          end
        end
      end
    endcase
  endtask

  task automatic tick(input logic [3:0] req);
    sw_rst_req = req;
    @(posedge clk);
    model_step(req);
    #1;
  endtask

  task automatic start_seq();
    rstn_i = 1'b0;
    sw_rst_req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    test_mode = 1'b0;
    model_reset();
    repeat (2) tick(4'b1111);
    checks++;
    if (got !== 6'b000001) begin
      errors++;
      $display("FAIL reset_state got %b want %b", got, 6'b000001);
    end
  endtask

  task automatic test_power_up();
    logic [3:0] want;
    int         n;
    start_seq();
    for (int e = 1; e <= 70; e++) begin
      tick(4'b0000);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL power_up_e%0d got %b want %b", e, got, exp_vec());
      end
      if (e % GAP == 1 || e % GAP == 2) begin
        n = (e < SYNC) ? 0 : (e - SYNC) / GAP;
        if (n > NCH) n = NCH;
        want = 4'((1 << n) - 1);
        checks++;
        if (rstn_o !== want || rst_done !== (n == NCH) || busy !== (n != NCH)) begin
          errors++;
          $display("FAIL release_edge_%0d got %b/%b/%b want %b/%b/%b", e, rstn_o, rst_done,
                   busy, want, (n == NCH), (n != NCH));
        end
      end
    end
  endtask

  task automatic test_soft_done();
    tick(4'b0100);
    checks++;
    if (got !== 6'b001101) begin
      errors++;
      $display("FAIL soft_done_enter got %b want %b", got, 6'b001101);
    end
    for (int i = 1; i <= 50; i++) begin
      tick(4'b0000);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL soft_done_i%0d got %b want %b", i, got, exp_vec());
      end
      if (i == 23 || i == 24 || i == 40) begin
        checks++;
        if (rstn_o !== ((i == 23) ? 4'b0011 : (i == 24) ? 4'b0111 : 4'b1111)) begin
          errors++;
          $display("FAIL soft_done_rel_i%0d got %b", i, rstn_o);
        end
      end
    end
  endtask

  task automatic test_hold_multi();
    for (int i = 0; i < 20; i++) begin
      tick((i < 5) ? 4'b1000 : 4'b1010);
      checks++;
      if (got !== exp_vec() || (i >= 5 && rstn_o !== 4'b0001)) begin
        errors++;
        $display("FAIL hold_held_i%0d got %b want %b", i, got, exp_vec());
      end
    end
    for (int i = 1; i <= 60; i++) begin
      tick(4'b0000);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL hold_rel_i%0d got %b want %b", i, got, exp_vec());
      end
      if (i == 23 || i == 24) begin
        checks++;
        if (rstn_o !== ((i == 23) ? 4'b0001 : 4'b0011)) begin
          errors++;
          $display("FAIL hold_ch1_i%0d got %b", i, rstn_o);
        end
      end
    end
  endtask

  task automatic test_collision();
    start_seq();
    for (int e = 1; e < 50; e++) tick(4'b0000);
    tick(4'b0010);
    checks++;
    if (got !== 6'b000101) begin
      errors++;
      $display("FAIL collision got %b want %b", got, 6'b000101);
    end
    for (int i = 0; i < 40; i++) begin
      tick(4'b0000);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL collision_i%0d got %b want %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_async_mid();
    start_seq();
    for (int e = 1; e <= 40; e++) tick(4'b0000);
    #2 rstn_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got !== 6'b000001) begin
      errors++;
      $display("FAIL async_mid got %b want %b", got, 6'b000001);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick(4'b0000);
      checks++;
      if (got !== exp_vec() || (e == 18 && rstn_o !== 4'b0001)
          || (e == 66 && got !== 6'b111110)) begin
        errors++;
        $display("FAIL async_rerun_e%0d got %b want %b", e, got, exp_vec());
      end
    end
  endtask

  task automatic test_test_mode();
    test_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 rstn_i = ~rstn_i;
      #1;
      checks++;
      if (rstn_o !== {4{rstn_i}} || rst_done !== rstn_i) begin
        errors++;
        $display("FAIL test_mode_toggle_%0d got %b/%b want %b", i, rstn_o, rst_done, rstn_i);
      end
    end
    start_seq();
    for (int e = 1; e <= 70; e++) begin
      tick(4'b0000);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL test_mode_e%0d got %b want %b", e, got, exp_vec());
      end
    end
    test_mode = 1'b0;
    #1;
    checks++;
    if (got !== 6'b111110) begin
      errors++;
      $display("FAIL test_mode_drop got %b want %b", got, 6'b111110);
    end
  endtask

  task automatic test_random();
    logic [3:0] req;
    int         hold_left;
    int         rst_at;
    for (int r = 0; r < 3; r++) begin
      start_seq();
      hold_left = 0;
      req = '0;
      rst_at = $urandom_range(100, 250);
      for (int c = 0; c < 300; c++) begin
        if (hold_left > 0) hold_left--;
        else if ($urandom_range(0, 9) == 0) begin
          req = 4'($urandom_range(1, 15));
          hold_left = $urandom_range(0, 11);
        end else req = '0;
        if ($urandom_range(0, 49) == 0) test_mode = ~test_mode;
        tick(req);
        checks++;
        if (got !== exp_vec()) begin
          errors++;
          $display("FAIL random_r%0d_c%0d got %b want %b req %b", r, c, got, exp_vec(), req);
        end
        if (c == rst_at) begin
          #2 rstn_i = 1'b0;
          model_reset();
          #1;
          checks++;
          if (got !== exp_vec()) begin
            errors++;
            $display("FAIL random_async_r%0d got %b want %b", r, got, exp_vec());
          end
          @(negedge clk);
          rstn_i = 1'b1;
        end
      end
      test_mode = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_soft_done();
    test_hold_multi();
    test_collision();
    test_async_mid();
    test_test_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
